sgen_nco_mc: RTL
================

// Module: sgen_nco_mc
// PURPOSE
//  Multi-channel, time-multiplexed NCO. It generates gp_channels independent sin/cos tones from one
//  quarter-wave ROM and one shared datapath, serving one channel per enabled clock (round-robin).
//  Each channel has its own FCW and phase offset. Configuration is double-buffered and committed
//  coherently at frame boundaries. Sits in the sgen_* family; feeds mixers and DUC/DDC channel banks.
// PARAMETERS
//  gp_channels          4   number of channels; >=2 (channel index width CW = $clog2(gp_channels))
//  gp_phase_accu_width  16  phase accumulator / FCW / offset width W; >= gp_rom_depth+2
//  gp_rom_depth         8   quarter-wave ROM address bits D (N = 2**D entries)
//  gp_rom_width         8   ROM magnitude bits R; outputs are signed R+1 bits
// PORTS
//  i_clk        in   1    clock
//  i_rst        in   1    synchronous reset, active-high
//  i_ena        in   1    slot enable; each high cycle issues one channel sample
//  i_cfg_wr     in   1    write i_cfg_* into shadow regs of channel i_cfg_ch
//  i_cfg_ch     in   CW   channel index for the shadow write
//  i_cfg_fcw    in   W    shadow frequency control word
//  i_cfg_poff   in   W    shadow phase offset
//  i_cfg_sync   in   1    shadow flag: clear this channel's accumulator at commit
//  i_cfg_commit in   1    request transfer of all shadow regs to active regs
//  o_cfg_busy   out  1    commit pending, not yet applied
//  o_valid      out  1    o_sin/o_cos/o_ch carry a new sample
//  o_ch         out  CW   channel index of the current sample
//  o_sin        out  R+1  signed sine sample
//  o_cos        out  R+1  signed cosine sample
// BEHAVIOUR
//  Reset (i_rst high at an edge): accumulators, active and shadow FCW/poff/sync, channel counter,
//   pending flag and pipeline valid bits -> 0; o_valid=0, o_ch=0, o_sin=0, o_cos=0, o_cfg_busy=0.
//   Overrides every other input in the same cycle, including a mid-frame or mid-pipeline reset.
//  Slot: an edge with i_ena=1. Channel c = counter. Phase p = acc[c] + poff[c] (mod 2**W).
//   Same edge: acc[c] <= acc[c] + fcw[c] (mod 2**W). Counter increments and wraps gp_channels-1 -> 0.
//  i_ena=0: no slot is issued; counter and accumulators hold. In-flight samples still drain.
//  Pipeline is not stallable. Latency 3: a slot at edge t gives o_valid=1 after edge t+3,
//   with o_ch=c. When no sample exits, o_valid=0 and o_sin/o_cos/o_ch hold their last values.
//  Lookup: q = p[W-1:W-2], k = p[W-3:W-2-D] (truncation, no dither).
//   ROM: rom[k] = round((2**R-1)*sin(2*pi*(k+0.5)/(4N))). The half-LSB offset makes the symmetry exact.
//   sin: q0 -> +rom[k], q1 -> +rom[N-1-k], q2 -> -rom[k], q3 -> -rom[N-1-k].
//   cos: same mapping with quadrant q+1 (mod 4). Outputs never reach +/-2**R, so there is no overflow.
//  Shadow write (i_cfg_wr): updates shadow fcw/poff/sync of i_cfg_ch only. Allowed at any time.
//  Commit: an i_cfg_commit pulse sets pending, so o_cfg_busy=1 from the next cycle. Repeated pulses
//   while pending are absorbed. Apply edge = next slot with counter=gp_channels-1, which may be the
//   same edge as the pulse. At the apply edge:
//   - all active fcw/poff <= shadow values as held before that edge;
//   - acc of every channel whose shadow sync=1 <= 0, overriding the ch N-1 increment;
//   - shadow sync bits <= 0; pending <= 0.
//   The following ch0 slot is the first to use the new configuration (frame-coherent).
//  Write and apply on the same edge: apply uses the old shadow value; the write lands for the next commit.
//  If i_ena stays low, the commit stays pending indefinitely (o_cfg_busy=1).
// TESTING  (W=16, D=8, R=8, 4 channels; rom[0]=1, rom[255]=255)
//  1 Reset: hold i_rst 2 cycles with i_ena=1 -> o_valid=0, o_sin=o_cos=0, o_ch=0, o_cfg_busy=0.
//  2 All channels fcw=0, poff=0, sync=1, commit, i_ena=1 -> samples for ch0..3 in order,
//    o_sin=+1, o_cos=+255; o_cfg_busy falls after the ch3 slot edge.
//  3 ch1 poff=0x4000 -> ch1 o_sin=+255, o_cos=-1; poff=0x8000 -> o_sin=-1, o_cos=-255.
//  4 ch2 fcw=0x0400, sync -> ch2 frame 16: o_sin=+255; frame 32: o_sin=-1; frame 64: back to +1
//    (wrap). Other channels are unaffected.
//  5 Write ch0/ch3 fcw while counter=1, commit -> both change from the same frame (next ch0 slot);
//    a write in the apply cycle is not applied until the next commit.
//  6 Drop i_ena for 5 cycles mid-frame -> exactly 3 trailing o_valid, then 0; resumes with the next
//    channel index, phases continuous. Assert i_rst mid-frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/sgen_nco_mc.sv
// Time-multiplexed multi-channel sin/cos NCO: one quarter-wave ROM and one datapath serve
// gp_channels round-robin, with double-buffered per-channel configuration committed once per frame.
module sgen_nco_mc #(
    parameter int gp_channels         = 4,
    parameter int gp_phase_accu_width = 16,
    parameter int gp_rom_depth        = 8,
    parameter int gp_rom_width        = 8
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_ena,
    input  logic                                      i_cfg_wr,
    input  logic [$clog2(gp_channels)-1:0]            i_cfg_ch,
    input  logic [gp_phase_accu_width-1:0]            i_cfg_fcw,
    input  logic [gp_phase_accu_width-1:0]            i_cfg_poff,
    input  logic                                      i_cfg_sync,
    input  logic                                      i_cfg_commit,
    output logic                                      o_cfg_busy,
    output logic                                      o_valid,
    output logic [$clog2(gp_channels)-1:0]            o_ch,
    output logic signed [gp_rom_width:0]              o_sin,
    output logic signed [gp_rom_width:0]              o_cos
);

    localparam int CW = $clog2(gp_channels);
    localparam int W  = gp_phase_accu_width;
    localparam int D  = gp_rom_depth;
    localparam int R  = gp_rom_width;
    localparam int N  = 2 ** D;
    localparam logic [CW-1:0] LAST_CH = CW'(gp_channels - 1);
    localparam longint PI_Q30 = 64'sd3373259426;

    // Quarter-wave sample k at angle pi*(2k+1)/(4N), Taylor series in Q2.30, rounded to R bits.
    function automatic longint rom_calc(input int k);
        longint x, term, sum;
        x    = (PI_Q30 * longint'(2 * k + 1)) / longint'(4 * N);
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return ((longint'(2 ** R - 1) * sum) + (64'sd1 <<< 29)) >>> 30;
    endfunction

    function automatic logic signed [R:0] apply_sign(input logic [R-1:0] mag, input logic neg);
        logic signed [R:0] m;
        m = $signed({1'b0, mag});
        return neg ? -m : m;
    endfunction

    logic [R-1:0] rom_w [N];
    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom_w[g] = R'(rom_calc(g));
    end

    logic [W-1:0]  acc_q     [gp_channels];
    logic [W-1:0]  fcw_q     [gp_channels];
    logic [W-1:0]  poff_q    [gp_channels];
    logic [W-1:0]  sh_fcw_q  [gp_channels];
    logic [W-1:0]  sh_poff_q [gp_channels];
    logic          sh_sync_q [gp_channels];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          last_ch, apply;
    logic [W-1:0]  phase_d;

    logic            vld_p0_q, vld_p1_q, vld_p2_q;
    logic [CW-1:0]   ch_p0_q, ch_p1_q, ch_p2_q;
    logic [D+1:0]    pidx_p0_q;
    logic [D-1:0]    sin_addr_p1_q, cos_addr_p1_q;
    logic            sin_neg_p1_q, cos_neg_p1_q;
    logic [R-1:0]    sin_mag_p2_q, cos_mag_p2_q;
    logic            sin_neg_p2_q, cos_neg_p2_q;

    always_comb begin
        last_ch = (cnt_q == LAST_CH);
        apply   = i_ena && last_ch && (pend_q || i_cfg_commit);
        cnt_d   = cnt_q;
        if (i_ena) begin
            cnt_d = last_ch ? '0 : cnt_q + CW'(1);
        end
        pend_d  = apply ? 1'b0 : (pend_q || i_cfg_commit);
        phase_d = acc_q[cnt_q] + poff_q[cnt_q];
    end

    // Only the quadrant and ROM address bits of the phase are used (truncation).
    if (W > D + 2) begin : g_phase_lsb
        logic unused_phase_lsb;
        assign unused_phase_lsb = ^phase_d[W-D-3:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            for (int i = 0; i < gp_channels; i++) begin
                acc_q[i]     <= '0;
                fcw_q[i]     <= '0;
                poff_q[i]    <= '0;
                sh_fcw_q[i]  <= '0;
                sh_poff_q[i] <= '0;
                sh_sync_q[i] <= 1'b0;
            end
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            vld_p0_q <= i_ena;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            if (i_ena) begin
                acc_q[cnt_q] <= acc_q[cnt_q] + fcw_q[cnt_q];
            end
            // Apply sees pre-edge shadows; a same-edge write below lands for the next commit.
            if (apply) begin
                for (int i = 0; i < gp_channels; i++) begin
                    fcw_q[i]     <= sh_fcw_q[i];
                    poff_q[i]    <= sh_poff_q[i];
                    sh_sync_q[i] <= 1'b0;
                    if (sh_sync_q[i]) begin
                        acc_q[i] <= '0;
                    end
                end
            end
            if (i_cfg_wr && (int'(i_cfg_ch) < gp_channels)) begin
                sh_fcw_q[i_cfg_ch]  <= i_cfg_fcw;
                sh_poff_q[i_cfg_ch] <= i_cfg_poff;
                sh_sync_q[i_cfg_ch] <= i_cfg_sync;
            end
        end
    end

    // p0: phase quadrant/address of the issued slot
    always_ff @(posedge i_clk) begin
        ch_p0_q   <= cnt_q;
        pidx_p0_q <= phase_d[W-1 -: D+2];
    end

    // p1: quadrant folding into ROM addresses and sign flags (cos uses quadrant+1)
    always_ff @(posedge i_clk) begin
        ch_p1_q       <= ch_p0_q;
        sin_addr_p1_q <= pidx_p0_q[D] ? ~pidx_p0_q[D-1:0] : pidx_p0_q[D-1:0];
        cos_addr_p1_q <= pidx_p0_q[D] ? pidx_p0_q[D-1:0] : ~pidx_p0_q[D-1:0];
        sin_neg_p1_q  <= pidx_p0_q[D+1];
        cos_neg_p1_q  <= pidx_p0_q[D+1] ^ pidx_p0_q[D];
    end

    // p2: ROM read
    always_ff @(posedge i_clk) begin
        ch_p2_q      <= ch_p1_q;
        sin_mag_p2_q <= rom_w[sin_addr_p1_q];
        cos_mag_p2_q <= rom_w[cos_addr_p1_q];
        sin_neg_p2_q <= sin_neg_p1_q;
        cos_neg_p2_q <= cos_neg_p1_q;
    end

    // output: sign application, values hold between samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_ch    <= '0;
            o_sin   <= '0;
            o_cos   <= '0;
        end else begin
            o_valid <= vld_p2_q;
            if (vld_p2_q) begin
                o_ch  <= ch_p2_q;
                o_sin <= apply_sign(sin_mag_p2_q, sin_neg_p2_q);
                o_cos <= apply_sign(cos_mag_p2_q, cos_neg_p2_q);
            end
        end
    end

    assign o_cfg_busy = pend_q;

endmodule
